// File: rtl/vec_chk_pkg.sv
// Shared definitions for the vector checker: FSM state encodings and a
// constant-foldable ceil(log2) used to size indices and counters.
package vec_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Smallest result such that 2**result >= value (0 for value <= 1).
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 32'sd0;
      rem    = value - 32'sd1;
      while (rem > 32'sd0) begin
         result = result + 32'sd1;
         rem    = rem >>> 32'sd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/vec_checker_if.sv
// Bus between the vector checker and its host: vector loading, run control,
// DUT stimulus/response and the result/status outputs.
interface vec_checker_if #(
   parameter int IN_W   = 3,
   parameter int OUT_W  = 1,
   parameter int ADDR_W = 3
);
   logic              ld_we;
   logic [ADDR_W-1:0] ld_addr;
   logic [IN_W-1:0]   ld_in;
   logic [OUT_W-1:0]  ld_exp;
   logic [OUT_W-1:0]  ld_mask;
   logic [ADDR_W:0]   n_vec;
   logic              mode_exh;
   logic              stop_on_fail;
   logic              start;
   logic [IN_W-1:0]   dut_x;
   logic [OUT_W-1:0]  dut_f;
   logic              busy;
   logic              done;
   logic              pass;
   logic [ADDR_W:0]   pass_cnt;
   logic [ADDR_W:0]   fail_cnt;
   logic              err_valid;
   logic [ADDR_W-1:0] err_idx;
   logic [OUT_W-1:0]  err_got;
   logic [OUT_W-1:0]  err_exp;

   // Host side: loads vectors, starts runs, models the DUT response.
   modport master (
      output ld_we, ld_addr, ld_in, ld_exp, ld_mask,
      output n_vec, mode_exh, stop_on_fail, start, dut_f,
      input  dut_x, busy, done, pass, pass_cnt, fail_cnt,
      input  err_valid, err_idx, err_got, err_exp
   );

   // Checker side.
   modport slave (
      input  ld_we, ld_addr, ld_in, ld_exp, ld_mask,
      input  n_vec, mode_exh, stop_on_fail, start, dut_f,
      output dut_x, busy, done, pass, pass_cnt, fail_cnt,
      output err_valid, err_idx, err_got, err_exp
   );
endinterface

// File: rtl/vec_chk_mem.sv
// Vector store: one word per slot holding {stimulus, expected, mask}.
// Synchronous write, asynchronous read, deliberately not reset so that a
// loaded table survives a reset of the checker.
module vec_chk_mem #(
   parameter int DEPTH  = 8,
   parameter int WORD_W = 5,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem_r [DEPTH];

   // Write port: store one slot per enabled edge.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/vec_checker.sv
// Self-checking vector engine: steps through stored vectors, drives the DUT
// stimulus, samples the DUT response LAT edges later, compares it under a
// mask and accumulates pass/fail counts plus first-failure capture.
module vec_checker
   import vec_chk_pkg::*;
#(
   parameter int IN_W   = 3,
   parameter int OUT_W  = 1,
   parameter int DEPTH  = 8,
   parameter int LAT    = 1,
   parameter int ADDR_W = clog2(DEPTH)
) (
   input logic         clk,
   input logic         rst_n,
   vec_checker_if.slave bus
);

   localparam int WORD_W = IN_W + 2 * OUT_W;
   localparam int CNT_W  = ADDR_W + 1;
   localparam int WCNT_W = clog2(LAT + 1);

   localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(32'd1);
   localparam logic [ADDR_W-1:0] IDX_ZERO  = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(32'd1);
   localparam logic [WCNT_W-1:0] WCNT_ZERO = {WCNT_W{1'b0}};
   localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(32'd1);
   localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(LAT - 1);

   state_t             state_r;
   state_t             next_state_s;
   logic [ADDR_W-1:0]  idx_r;
   logic [CNT_W-1:0]   limit_r;
   logic               mode_exh_r;
   logic               stop_r;
   logic [WCNT_W-1:0]  wcnt_r;
   logic [IN_W-1:0]    dut_x_r;
   logic               busy_r;
   logic               done_r;
   logic               pass_r;
   logic [CNT_W-1:0]   pass_cnt_r;
   logic [CNT_W-1:0]   fail_cnt_r;
   logic               err_valid_r;
   logic [ADDR_W-1:0]  err_idx_r;
   logic [OUT_W-1:0]   err_got_r;
   logic [OUT_W-1:0]   err_exp_r;

   logic [WORD_W-1:0]  rdata_s;
   logic [IN_W-1:0]    ram_in_s;
   logic [OUT_W-1:0]   ram_exp_s;
   logic [OUT_W-1:0]   ram_mask_s;
   logic [CNT_W-1:0]   limit_s;
   logic [IN_W-1:0]    stim_s;
   logic               mismatch_s;
   logic               last_s;
   logic               start_run_s;
   logic               apply_s;
   logic               cmp_s;
   logic               finish_s;

   // Loads are blocked while a run is reading the table.
   vec_chk_mem #(
      .DEPTH  (DEPTH),
      .WORD_W (WORD_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (bus.ld_we & ~busy_r),
      .waddr (bus.ld_addr),
      .wdata ({bus.ld_in, bus.ld_exp, bus.ld_mask}),
      .raddr (idx_r),
      .rdata (rdata_s)
   );

   assign ram_in_s   = rdata_s[WORD_W-1 -: IN_W];
   assign ram_exp_s  = rdata_s[2*OUT_W-1 -: OUT_W];
   assign ram_mask_s = rdata_s[OUT_W-1:0];

   assign limit_s    = (bus.n_vec > DEPTH_C) ? DEPTH_C : bus.n_vec;
   assign stim_s     = mode_exh_r ? IN_W'(idx_r) : ram_in_s;
   assign mismatch_s = |((bus.dut_f ^ ram_exp_s) & ram_mask_s);
   assign last_s     = ({1'b0, idx_r} == (limit_r - CNT_ONE));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start_run_s) begin
               next_state_s = (limit_s == CNT_ZERO) ? ST_DONE : ST_APPLY;
            end else begin
               next_state_s = state_r;
            end
         end
         ST_APPLY: next_state_s = ST_WAIT;
         ST_WAIT: begin
            if (finish_s) begin
               next_state_s = ST_DONE;
            end else if (cmp_s) begin
               next_state_s = ST_APPLY;
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // Per-state control strobes for the datapath.
   always_comb begin
      start_run_s = 1'b0;
      apply_s     = 1'b0;
      cmp_s       = 1'b0;
      finish_s    = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               start_run_s = 1'b1;
            end else begin
               start_run_s = 1'b0;
            end
         end
         ST_APPLY: apply_s = 1'b1;
         ST_WAIT: begin
            if (wcnt_r == WCNT_ZERO) begin
               cmp_s = 1'b1;
               if ((mismatch_s && stop_r) || last_s) begin
                  finish_s = 1'b1;
               end else begin
                  finish_s = 1'b0;
               end
            end else begin
               cmp_s    = 1'b0;
               finish_s = 1'b0;
            end
         end
         default: begin
            start_run_s = 1'b0;
            apply_s     = 1'b0;
            cmp_s       = 1'b0;
            finish_s    = 1'b0;
         end
      endcase
   end

   // Datapath: run setup, stimulus drive, latency count, compare and capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r       <= IDX_ZERO;
         limit_r     <= CNT_ZERO;
         mode_exh_r  <= 1'b0;
         stop_r      <= 1'b0;
         wcnt_r      <= WCNT_ZERO;
         dut_x_r     <= {IN_W{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         pass_cnt_r  <= CNT_ZERO;
         fail_cnt_r  <= CNT_ZERO;
         err_valid_r <= 1'b0;
         err_idx_r   <= IDX_ZERO;
         err_got_r   <= {OUT_W{1'b0}};
         err_exp_r   <= {OUT_W{1'b0}};
      end else if (start_run_s) begin
         idx_r       <= IDX_ZERO;
         limit_r     <= limit_s;
         mode_exh_r  <= bus.mode_exh;
         stop_r      <= bus.stop_on_fail;
         pass_cnt_r  <= CNT_ZERO;
         fail_cnt_r  <= CNT_ZERO;
         err_valid_r <= 1'b0;
         err_idx_r   <= IDX_ZERO;
         err_got_r   <= {OUT_W{1'b0}};
         err_exp_r   <= {OUT_W{1'b0}};
         if (limit_s == CNT_ZERO) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            pass_r <= 1'b1;
         end else begin
            busy_r <= 1'b1;
            done_r <= 1'b0;
            pass_r <= 1'b0;
         end
      end else if (apply_s) begin
         dut_x_r <= stim_s;
         wcnt_r  <= WAIT_INIT;
      end else if (cmp_s) begin
         if (mismatch_s) begin
            fail_cnt_r <= fail_cnt_r + CNT_ONE;
            if (!err_valid_r) begin
               err_valid_r <= 1'b1;
               err_idx_r   <= idx_r;
               err_got_r   <= bus.dut_f;
               err_exp_r   <= ram_exp_s;
            end
         end else begin
            pass_cnt_r <= pass_cnt_r + CNT_ONE;
         end
         if (finish_s) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            pass_r <= (fail_cnt_r == CNT_ZERO) && !mismatch_s;
         end else begin
            idx_r <= idx_r + IDX_ONE;
         end
      end else if (state_r == ST_WAIT) begin
         wcnt_r <= wcnt_r - WCNT_ONE;
      end
   end

   assign bus.dut_x     = dut_x_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.pass      = pass_r;
   assign bus.pass_cnt  = pass_cnt_r;
   assign bus.fail_cnt  = fail_cnt_r;
   assign bus.err_valid = err_valid_r;
   assign bus.err_idx   = err_idx_r;
   assign bus.err_got   = err_got_r;
   assign bus.err_exp   = err_exp_r;

endmodule

// File: tb/tb_vec_checker.sv
// Bench for vec_checker driving a 3-input majority function as the DUT.
// A reference model predicts each run; expected stimulus values are queued
// when a run is started and popped as each vector appears on dut_x.
module tb_vec_checker;
   localparam int IN_W = 3, OUT_W = 1, DEPTH = 8, LAT = 1, ADDR_W = 3;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   vec_checker_if #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus();

   vec_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .LAT(LAT), .ADDR_W(ADDR_W))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic maj(input logic [2:0] x);
      return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
   endfunction

   assign bus.dut_f = maj(bus.dut_x);

   // Mirror of the vector table and model predictions.
   logic [2:0] m_in   [DEPTH];
   logic       m_exp  [DEPTH];
   logic       m_mask [DEPTH];
   logic [2:0] sb_q   [$];
   int         e_pass, e_fail, e_edges, e_idx;
   logic       e_errv, e_got, e_exp;

   function automatic void predict(input int n, input logic mode, input logic stop);
      int limit;
      logic [2:0] x;
      logic f, mism;
      limit = (n > DEPTH) ? DEPTH : n;
      e_pass = 0; e_fail = 0; e_edges = 0; e_idx = 0;
      e_errv = 1'b0; e_got = 1'b0; e_exp = 1'b0;
      for (int i = 0; i < limit; i++) begin
         x = mode ? 3'(i) : m_in[i];
         f = maj(x);
         sb_q.push_back(x);
         e_edges = (i + 1) * (LAT + 1);
         mism = ((f ^ m_exp[i]) & m_mask[i]) != 1'b0;
         if (mism) begin
            e_fail++;
            if (!e_errv) begin
               e_errv = 1'b1; e_idx = i; e_got = f; e_exp = m_exp[i];
            end
            if (stop) break;
         end else begin
            e_pass++;
         end
      end
   endfunction

   task automatic load_slot(input int a, input logic [2:0] x, input logic e, input logic m);
      @(negedge clk);
      bus.ld_we = 1'b1; bus.ld_addr = 3'(a); bus.ld_in = x; bus.ld_exp = e; bus.ld_mask = m;
      @(negedge clk);
      bus.ld_we = 1'b0;
      m_in[a] = x; m_exp[a] = e; m_mask[a] = m;
   endtask

   // Start a run, scoreboard dut_x per vector, return edges from start to done.
   // With poke set, a start pulse and a table write are attempted mid-run.
   task automatic do_run(input int n, input logic mode, input logic stop, input logic poke,
                         output int edges);
      logic [2:0] want;
      bit seen;
      predict(n, mode, stop);
      @(negedge clk);
      bus.n_vec = 4'(n); bus.mode_exh = mode; bus.stop_on_fail = stop; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.n_vec = 4'd1; bus.mode_exh = ~mode; bus.stop_on_fail = ~stop;
      edges = 0;
      seen = bus.done;
      for (int k = 1; k <= 400 && !seen; k++) begin
         @(posedge clk); #1;
         if (poke && k == 6) begin
            bus.start = 1'b0; bus.ld_we = 1'b0;
         end
         if ((k % (LAT + 1)) == 1 && sb_q.size() > 0) begin
            want = sb_q.pop_front();
            checks++;
            if (bus.dut_x !== want) begin
               failures++;
               $display("FAIL dut_x_seq edge=%0d: got %0d want %0d", k, bus.dut_x, want);
            end
         end
         if (poke && k == 5) begin
            bus.start = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 3'd3;
            bus.ld_in = m_in[3]; bus.ld_exp = ~m_exp[3]; bus.ld_mask = 1'b1;
         end
         if (bus.done) begin
            seen = 1'b1; edges = k;
         end
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL run_timeout: done never rose, want after %0d edges", e_edges);
      end
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL vectors_applied: %0d expected vectors never seen, want 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.ld_we = 1'b0; bus.ld_addr = 3'd0; bus.ld_in = 3'd0; bus.ld_exp = 1'b0; bus.ld_mask = 1'b0;
      bus.n_vec = 4'd0; bus.mode_exh = 1'b0; bus.stop_on_fail = 1'b0; bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.pass, bus.err_valid} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags: got busy/done/pass/err_valid=%b want 0000",
                  {bus.busy, bus.done, bus.pass, bus.err_valid});
      end
      checks++;
      if (bus.dut_x !== 3'd0) begin
         failures++; $display("FAIL reset_dut_x: got %0d want 0", bus.dut_x);
      end
      checks++;
      if ({bus.pass_cnt, bus.fail_cnt} !== 8'd0) begin
         failures++; $display("FAIL reset_counters: got %0d/%0d want 0/0", bus.pass_cnt, bus.fail_cnt);
      end
      checks++;
      if ({bus.err_idx, bus.err_got, bus.err_exp} !== 5'd0) begin
         failures++; $display("FAIL reset_err: got %0d/%0d/%0d want 0/0/0", bus.err_idx, bus.err_got, bus.err_exp);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_exhaustive;
      int edges;
      for (int i = 0; i < DEPTH; i++) load_slot(i, 3'(i), maj(3'(i)), 1'b1);
      do_run(8, 1'b1, 1'b0, 1'b0, edges);
      checks++;
      if (edges !== 16) begin failures++; $display("FAIL exh_latency: got %0d edges want 16", edges); end
      checks++;
      if (bus.pass_cnt !== 4'd8 || bus.fail_cnt !== 4'd0) begin
         failures++; $display("FAIL exh_counts: got %0d/%0d want 8/0", bus.pass_cnt, bus.fail_cnt);
      end
      checks++;
      if ({bus.busy, bus.done, bus.pass, bus.err_valid} !== 4'b0110) begin
         failures++; $display("FAIL exh_flags: got busy/done/pass/err_valid=%b want 0110",
                              {bus.busy, bus.done, bus.pass, bus.err_valid});
      end
   endtask

   task automatic test_single_fail;
      int edges;
      load_slot(5, 3'd5, 1'b0, 1'b1);
      do_run(8, 1'b1, 1'b0, 1'b0, edges);
      checks++;
      if (edges !== e_edges) begin failures++; $display("FAIL fail1_latency: got %0d want %0d", edges, e_edges); end
      checks++;
      if (bus.pass_cnt !== 4'(e_pass) || bus.fail_cnt !== 4'(e_fail)) begin
         failures++; $display("FAIL fail1_counts: got %0d/%0d want %0d/%0d", bus.pass_cnt, bus.fail_cnt, e_pass, e_fail);
      end
      checks++;
      if ({bus.err_valid, bus.err_idx, bus.err_got, bus.err_exp} !== {1'b1, 3'd5, 1'b1, 1'b0}) begin
         failures++; $display("FAIL fail1_capture: got v=%0d idx=%0d got=%0d exp=%0d want 1/5/1/0",
                              bus.err_valid, bus.err_idx, bus.err_got, bus.err_exp);
      end
      checks++;
      if (bus.pass !== 1'b0) begin failures++; $display("FAIL fail1_pass: got %0d want 0", bus.pass); end
   endtask

   task automatic test_stop_on_fail;
      int edges;
      load_slot(2, 3'd2, 1'b1, 1'b1);
      do_run(8, 1'b1, 1'b1, 1'b0, edges);
      checks++;
      if (edges !== 6) begin failures++; $display("FAIL stop_latency: got %0d edges want 6", edges); end
      checks++;
      if (bus.pass_cnt !== 4'd2 || bus.fail_cnt !== 4'd1) begin
         failures++; $display("FAIL stop_counts: got %0d/%0d want 2/1", bus.pass_cnt, bus.fail_cnt);
      end
      checks++;
      if ({bus.err_idx, bus.err_got, bus.err_exp, bus.dut_x} !== {3'd2, 1'b0, 1'b1, 3'd2}) begin
         failures++; $display("FAIL stop_capture: got idx=%0d got=%0d exp=%0d x=%0d want 2/0/1/2",
                              bus.err_idx, bus.err_got, bus.err_exp, bus.dut_x);
      end
   endtask

   task automatic test_mask_and_stored;
      int edges;
      load_slot(2, 3'd2, 1'b0, 1'b1);
      load_slot(5, 3'd5, 1'b0, 1'b0);
      do_run(8, 1'b1, 1'b0, 1'b0, edges);
      checks++;
      if (bus.pass !== 1'b1 || bus.fail_cnt !== 4'd0 || bus.pass_cnt !== 4'd8) begin
         failures++; $display("FAIL mask: got pass=%0d fail=%0d pcnt=%0d want 1/0/8", bus.pass, bus.fail_cnt, bus.pass_cnt);
      end
      for (int i = 0; i < DEPTH; i++) load_slot(i, 3'(7 - i), maj(3'(7 - i)), 1'b1);
      do_run(8, 1'b0, 1'b0, 1'b0, edges);
      checks++;
      if (bus.pass !== 1'b1 || bus.pass_cnt !== 4'(e_pass) || edges !== e_edges) begin
         failures++; $display("FAIL stored: got pass=%0d pcnt=%0d edges=%0d want 1/%0d/%0d",
                              bus.pass, bus.pass_cnt, edges, e_pass, e_edges);
      end
      checks++;
      if (bus.dut_x !== 3'd0) begin failures++; $display("FAIL stored_hold: got %0d want 0", bus.dut_x); end
   endtask

   task automatic test_limits;
      int edges;
      do_run(0, 1'b0, 1'b0, 1'b0, edges);
      checks++;
      if (edges !== 0 || bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.busy !== 1'b0) begin
         failures++; $display("FAIL nvec0: got edges=%0d done=%0d pass=%0d busy=%0d want 0/1/1/0",
                              edges, bus.done, bus.pass, bus.busy);
      end
      checks++;
      if (bus.pass_cnt !== 4'd0 || bus.fail_cnt !== 4'd0) begin
         failures++; $display("FAIL nvec0_counts: got %0d/%0d want 0/0", bus.pass_cnt, bus.fail_cnt);
      end
      do_run(12, 1'b0, 1'b0, 1'b0, edges);
      checks++;
      if (bus.pass_cnt !== 4'd8 || edges !== 16) begin
         failures++; $display("FAIL nvec12: got pcnt=%0d edges=%0d want 8/16", bus.pass_cnt, edges);
      end
   endtask

   task automatic test_reset_midrun;
      int edges;
      @(negedge clk);
      bus.n_vec = 4'd8; bus.mode_exh = 1'b0; bus.stop_on_fail = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      checks++;
      if (bus.dut_x !== m_in[4] || bus.busy !== 1'b1) begin
         failures++; $display("FAIL midrun_vec4: got x=%0d busy=%0d want %0d/1", bus.dut_x, bus.busy, m_in[4]);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.dut_x !== 3'd0 || bus.pass_cnt !== 4'd0 || bus.fail_cnt !== 4'd0) begin
         failures++; $display("FAIL midrun_reset: got busy=%0d x=%0d cnt=%0d/%0d want 0/0/0/0",
                              bus.busy, bus.dut_x, bus.pass_cnt, bus.fail_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_run(8, 1'b0, 1'b0, 1'b0, edges);
      checks++;
      if (bus.pass !== 1'b1 || bus.pass_cnt !== 4'd8) begin
         failures++; $display("FAIL after_reset_run: got pass=%0d pcnt=%0d want 1/8", bus.pass, bus.pass_cnt);
      end
   endtask

   task automatic test_back_to_back;
      int edges;
      do_run(8, 1'b0, 1'b0, 1'b1, edges);
      checks++;
      if (edges !== 16 || bus.pass !== 1'b1 || bus.fail_cnt !== 4'd0) begin
         failures++; $display("FAIL busy_ignore: got edges=%0d pass=%0d fail=%0d want 16/1/0",
                              edges, bus.pass, bus.fail_cnt);
      end
      do_run(8, 1'b1, 1'b0, 1'b0, edges);
      checks++;
      if (bus.pass_cnt !== 4'(e_pass) || bus.fail_cnt !== 4'(e_fail) || bus.pass !== 1'b0) begin
         failures++; $display("FAIL b2b_counts: got %0d/%0d pass=%0d want %0d/%0d/0",
                              bus.pass_cnt, bus.fail_cnt, bus.pass, e_pass, e_fail);
      end
      checks++;
      if (bus.err_idx !== 3'(e_idx) || bus.err_got !== e_got || bus.err_exp !== e_exp) begin
         failures++; $display("FAIL b2b_capture: got idx=%0d got=%0d exp=%0d want %0d/%0d/%0d",
                              bus.err_idx, bus.err_got, bus.err_exp, e_idx, e_got, e_exp);
      end
   endtask

   initial begin
      test_reset();
      test_exhaustive();
      test_single_fail();
      test_stop_on_fail();
      test_mask_and_stored();
      test_limits();
      test_reset_midrun();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "global timeout");
   end

endmodule
